pic_cmd_regfile: RTL and testbench

Clocked successor to the 8259 read/write command logic: synchronises the asynchronous CPU bus strobes into the system clock domain and runs the ICW1–ICW4 initialisation sequence as an explicit FSM. It decodes OCW1–OCW3 and holds every programmed word in registers. It drives the read-select code and one-cycle command pulses consumed by the priority/control logic. New versus the previous generation: parametrised synchroniser depth and IMR reset value, ICW1 re-initialisation at any time, OCW3 poll and special-mask handling, and sequence-error reporting.

---
 rtl/pic_cmd_regfile_if.sv | 12 +
 rtl/pic_cmd_regfile.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pic_cmd_regfile.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pic_cmd_regfile_if.sv
// CPU-side bus of the 8259-style command register file: asynchronous
// active-low strobes, address bit and write data.
interface pic_cmd_regfile_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] din;

    modport master (output cs_n, rd_n, wr_n, a0, din);
    modport slave  (input  cs_n, rd_n, wr_n, a0, din);
endinterface

// File: rtl/pic_cmd_regfile.sv
// Clocked 8259 command logic: strobe synchronisers, ICW1-ICW4 init FSM,
// OCW1-OCW3 decode, read-select generation and one-cycle command pulses.
//
// Bus handshake: a write is a CPU strobe, not a valid/ready transfer. The
// strobe (cs_n & wr_n low) is synchronised; din/a0 are sampled every cycle
// it is seen active, and the write commits exactly once on its
// synchronised falling edge. Commits are reported by single-cycle pulses
// (wr_stb_o/wr_type_o, ocw2_stb_o, seq_err_o) with no back-pressure.
module pic_cmd_regfile #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IMR_RESET   = 8'h00
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pic_cmd_regfile_if.slave    bus,
    output logic [7:0]          icw1_o,
    output logic [7:0]          icw2_o,
    output logic [7:0]          icw3_o,
    output logic [7:0]          icw4_o,
    output logic [7:0]          imr_o,
    output logic [7:0]          ocw2_o,
    output logic                ocw2_stb_o,
    output logic                smm_o,
    output logic                poll_pend_o,
    output logic [1:0]          rd_sel_o,
    output logic                rd_en_o,
    output logic                init_done_o,
    output logic [2:0]          wr_type_o,
    output logic                wr_stb_o,
    output logic                seq_err_o,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_ICW2 = 3'd1,
        S_W_ICW3 = 3'd2,
        S_W_ICW4 = 3'd3,
        S_READY  = 3'd4
    } state_t;

    localparam int CW = $clog2(SYNC_STAGES + 1);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q;
    logic                   wr_act, rd_act, wr_s, rd_s;
    logic                   wr_prev_q, rd_prev_q;
    logic                   wr_arm_q, rd_arm_q;
    logic [CW-1:0]          settle_q;
    logic                   settled;
    logic                   wr_fall, rd_fall, rd_rise;
    logic                   rd_first_q;
    logic                   hold_a0_q, rd_a0_q;
    logic [7:0]             hold_din_q;
    logic                   is_icw1;
    logic                   poll_set;

    logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic [7:0] imr_q, imr_d, ocw2_q, ocw2_d;
    logic       rmode_q, rmode_d;
    logic       smm_q, smm_d, poll_q, poll_d;
    logic       wr_stb_q, wr_stb_d, ocw2_stb_q, ocw2_stb_d, seq_err_q, seq_err_d;
    logic [2:0] wr_type_q, wr_type_d;

    assign wr_act  = ~bus.cs_n & ~bus.wr_n;
    assign rd_act  = ~bus.cs_n & ~bus.rd_n;
    assign wr_s    = wr_sync_q[SYNC_STAGES-1];
    assign rd_s    = rd_sync_q[SYNC_STAGES-1];
    assign settled = (settle_q == CW'(SYNC_STAGES));

    // Edges only count once a strobe has been seen inactive after the
    // synchronisers refilled post-reset, so a strobe held across reset is ignored.
    assign wr_fall = wr_arm_q & wr_prev_q & ~wr_s;
    assign rd_fall = rd_arm_q & rd_prev_q & ~rd_s;
    assign rd_rise = rd_arm_q & ~rd_prev_q & rd_s;
    assign is_icw1 = ~hold_a0_q & hold_din_q[4];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_sync_q  <= '0;
            rd_sync_q  <= '0;
            wr_prev_q  <= 1'b0;
            rd_prev_q  <= 1'b0;
            wr_arm_q   <= 1'b0;
            rd_arm_q   <= 1'b0;
            settle_q   <= '0;
            rd_first_q <= 1'b0;
            hold_a0_q  <= 1'b0;
            hold_din_q <= 8'h00;
            rd_a0_q    <= 1'b0;
        end else begin
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_act};
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rd_act};
            wr_prev_q <= wr_s;
            rd_prev_q <= rd_s;
            if (!settled) settle_q <= settle_q + CW'(1);
            if (settled && !wr_s) wr_arm_q <= 1'b1;
            if (settled && !rd_s) rd_arm_q <= 1'b1;
            if (rd_rise) rd_first_q <= ~wr_s;
            if (wr_s) begin
                hold_a0_q  <= bus.a0;
                hold_din_q <= bus.din;
            end
            if (rd_s) rd_a0_q <= bus.a0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        icw1_d     = icw1_q;
        icw2_d     = icw2_q;
        icw3_d     = icw3_q;
        icw4_d     = icw4_q;
        imr_d      = imr_q;
        ocw2_d     = ocw2_q;
        rmode_d    = rmode_q;
        smm_d      = smm_q;
        poll_d     = poll_q;
        poll_set   = 1'b0;
        wr_stb_d   = 1'b0;
        wr_type_d  = wr_type_q;
        ocw2_stb_d = 1'b0;
        seq_err_d  = 1'b0;

        if (wr_fall) begin
            if (rd_s) begin
                seq_err_d = 1'b1;
            end else if (is_icw1) begin
                icw1_d    = hold_din_q;
                icw2_d    = 8'h00;
                icw3_d    = 8'h00;
                icw4_d    = 8'h00;
                imr_d     = IMR_RESET;
                smm_d     = 1'b0;
                poll_d    = 1'b0;
                rmode_d   = 1'b0;
                wr_stb_d  = 1'b1;
                wr_type_d = 3'd0;
                state_d   = S_W_ICW2;
            end else begin
                case (state_q)
                    S_W_ICW2: begin
                        if (hold_a0_q) begin
                            icw2_d    = hold_din_q;
                            wr_stb_d  = 1'b1;
                            wr_type_d = 3'd1;
                            if (!icw1_q[1])     state_d = S_W_ICW3;
                            else if (icw1_q[0]) state_d = S_W_ICW4;
                            else                state_d = S_READY;
                        end else begin
                            seq_err_d = 1'b1;
                        end
                    end
                    S_W_ICW3: begin
                        if (hold_a0_q) begin
                            icw3_d    = hold_din_q;
                            wr_stb_d  = 1'b1;
                            wr_type_d = 3'd2;
                            state_d   = icw1_q[0] ? S_W_ICW4 : S_READY;
                        end else begin
                            seq_err_d = 1'b1;
                        end
                    end
                    S_W_ICW4: begin
                        if (hold_a0_q) begin
                            icw4_d    = hold_din_q;
                            wr_stb_d  = 1'b1;
                            wr_type_d = 3'd3;
                            state_d   = S_READY;
                        end else begin
                            seq_err_d = 1'b1;
                        end
                    end
                    S_READY: begin
                        if (hold_a0_q) begin
                            imr_d     = hold_din_q;
                            wr_stb_d  = 1'b1;
                            wr_type_d = 3'd4;
                        end else begin
                            case (hold_din_q[4:3])
                                2'b00: begin
                                    ocw2_d     = hold_din_q;
                                    ocw2_stb_d = 1'b1;
                                    wr_stb_d   = 1'b1;
                                    wr_type_d  = 3'd5;
                                end
                                2'b01: begin
                                    if (hold_din_q[1]) rmode_d = hold_din_q[0];
                                    if (hold_din_q[2]) begin
                                        poll_d   = 1'b1;
                                        poll_set = 1'b1;
                                    end
                                    if (hold_din_q[6]) smm_d = hold_din_q[5];
                                    wr_stb_d  = 1'b1;
                                    wr_type_d = 3'd6;
                                end
                                default: seq_err_d = 1'b1;
                            endcase
                        end
                    end
                    default: seq_err_d = 1'b1;
                endcase
            end
        end

        // A read that began before the OCW3 write overrides that write's poll set.
        if (rd_fall && !rd_a0_q && (!poll_set || rd_first_q)) poll_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            icw1_q     <= 8'h00;
            icw2_q     <= 8'h00;
            icw3_q     <= 8'h00;
            icw4_q     <= 8'h00;
            imr_q      <= IMR_RESET;
            ocw2_q     <= 8'h00;
            rmode_q    <= 1'b0;
            smm_q      <= 1'b0;
            poll_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_type_q  <= 3'd0;
            ocw2_stb_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            icw1_q     <= icw1_d;
            icw2_q     <= icw2_d;
            icw3_q     <= icw3_d;
            icw4_q     <= icw4_d;
            imr_q      <= imr_d;
            ocw2_q     <= ocw2_d;
            rmode_q    <= rmode_d;
            smm_q      <= smm_d;
            poll_q     <= poll_d;
            wr_stb_q   <= wr_stb_d;
            wr_type_q  <= wr_type_d;
            ocw2_stb_q <= ocw2_stb_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign icw1_o      = icw1_q;
    assign icw2_o      = icw2_q;
    assign icw3_o      = icw3_q;
    assign icw4_o      = icw4_q;
    assign imr_o       = imr_q;
    assign ocw2_o      = ocw2_q;
    assign ocw2_stb_o  = ocw2_stb_q;
    assign smm_o       = smm_q;
    assign poll_pend_o = poll_q;
    assign rd_en_o     = rd_s;
    assign init_done_o = (state_q == S_READY);
    assign wr_type_o   = wr_type_q;
    assign wr_stb_o    = wr_stb_q;
    assign seq_err_o   = seq_err_q;
    assign state_o     = state_q;

    always_comb begin
        if (bus.a0)      rd_sel_o = 2'b10;
        else if (poll_q) rd_sel_o = 2'b11;
        else             rd_sel_o = {1'b0, rmode_q};
    end

endmodule

// File: tb/tb_pic_cmd_regfile.sv
// Bench for pic_cmd_regfile: vector table of bus writes/reads with register
// expectations, a pulse scoreboard, and hand-written reset/overlap sequences.
module tb_pic_cmd_regfile;
  localparam int         SYNC = 2;
  localparam logic [7:0] IMRR = 8'h3C;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_W2 = 3'd1, ST_W3 = 3'd2,
                         ST_W4 = 3'd3, ST_RDY = 3'd4;
  // Pulse word: {ocw2_stb, seq_err, wr_stb, wr_type}
  localparam logic [5:0] EV_ERR  = 6'b010_000;
  localparam logic [5:0] EV_OCW2 = 6'b101_101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] icw1, icw2, icw3, icw4, imr, ocw2;
  logic       ocw2_stb, smm, poll_pend, rd_en, init_done, wr_stb, seq_err;
  logic [1:0] rd_sel;
  logic [2:0] wr_type, state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  pic_cmd_regfile_if bus();

  pic_cmd_regfile #(.SYNC_STAGES(SYNC), .IMR_RESET(IMRR)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave),
    .icw1_o(icw1), .icw2_o(icw2), .icw3_o(icw3), .icw4_o(icw4),
    .imr_o(imr), .ocw2_o(ocw2), .ocw2_stb_o(ocw2_stb), .smm_o(smm),
    .poll_pend_o(poll_pend), .rd_sel_o(rd_sel), .rd_en_o(rd_en),
    .init_done_o(init_done), .wr_type_o(wr_type), .wr_stb_o(wr_stb),
    .seq_err_o(seq_err), .state_o(state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ev_w(input logic [2:0] t);
    return {3'b001, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every pulse cycle must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && (wr_stb || seq_err || ocw2_stb)) begin
      logic [5:0] act;
      act = {ocw2_stb, seq_err, wr_stb, wr_stb ? wr_type : 3'd0};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got %0h expected none", act);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL pulse: got %0h expected %0h", act, e);
        end
      end
    end
  end

  task automatic bus_write(input logic a, input logic [7:0] d, input logic [5:0] ev);
    int n;
    exp_q.push_back(ev);
    @(negedge clk);
    bus.a0 = a; bus.din = d; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    bus.wr_n = 1'b1; bus.cs_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr_stb || seq_err) && n < 20);
    check("commit_latency", n, SYNC + 1);
    repeat (SYNC + 2) @(negedge clk);
    bus.a0 = 1'b0;
  endtask

  task automatic bus_read(input logic a);
    @(negedge clk);
    bus.a0 = a; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (SYNC - 1) @(negedge clk);
    check("rd_en_early", rd_en, 0);
    @(negedge clk);
    check("rd_en_on", rd_en, 1);
    repeat (SYNC + 1) @(negedge clk);
    bus.rd_n = 1'b1; bus.cs_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    check("rd_en_off", rd_en, 0);
    bus.a0 = 1'b0;
  endtask

  typedef struct {
    logic        is_rd;
    logic        a0;
    logic [7:0]  din;
    logic [5:0]  ev;
    logic [2:0]  st;
    logic [7:0]  imr;
    logic [1:0]  sel;
    logic        smm;
    logic        poll;
    logic [31:0] icws;
    logic [7:0]  ocw2;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'h12, ev_w(3'd0), ST_W2,  IMRR,  2'd0, 1'b0, 1'b0, 32'h12000000, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h20, ev_w(3'd1), ST_RDY, IMRR,  2'd0, 1'b0, 1'b0, 32'h12200000, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h11, ev_w(3'd0), ST_W2,  IMRR,  2'd0, 1'b0, 1'b0, 32'h11000000, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, EV_ERR,     ST_W2,  IMRR,  2'd0, 1'b0, 1'b0, 32'h11000000, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 8'h40, ev_w(3'd1), ST_W3,  IMRR,  2'd0, 1'b0, 1'b0, 32'h11400000, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 8'h04, ev_w(3'd2), ST_W4,  IMRR,  2'd0, 1'b0, 1'b0, 32'h11400400, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 8'h01, ev_w(3'd3), ST_RDY, IMRR,  2'd0, 1'b0, 1'b0, 32'h11400401, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 8'hA5, ev_w(3'd4), ST_RDY, 8'hA5, 2'd0, 1'b0, 1'b0, 32'h11400401, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 8'h0B, ev_w(3'd6), ST_RDY, 8'hA5, 2'd1, 1'b0, 1'b0, 32'h11400401, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 8'h0A, ev_w(3'd6), ST_RDY, 8'hA5, 2'd0, 1'b0, 1'b0, 32'h11400401, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h0B, ev_w(3'd6), ST_RDY, 8'hA5, 2'd1, 1'b0, 1'b0, 32'h11400401, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h0C, ev_w(3'd6), ST_RDY, 8'hA5, 2'd3, 1'b0, 1'b1, 32'h11400401, 8'h00};
    vecs[12] = '{1'b1, 1'b1, 8'h00, 6'd0,       ST_RDY, 8'hA5, 2'd3, 1'b0, 1'b1, 32'h11400401, 8'h00};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 6'd0,       ST_RDY, 8'hA5, 2'd1, 1'b0, 1'b0, 32'h11400401, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 8'h68, ev_w(3'd6), ST_RDY, 8'hA5, 2'd1, 1'b1, 1'b0, 32'h11400401, 8'h00};
    vecs[15] = '{1'b0, 1'b0, 8'h48, ev_w(3'd6), ST_RDY, 8'hA5, 2'd1, 1'b0, 1'b0, 32'h11400401, 8'h00};
    vecs[16] = '{1'b0, 1'b0, 8'hE7, EV_OCW2,    ST_RDY, 8'hA5, 2'd1, 1'b0, 1'b0, 32'h11400401, 8'hE7};
    vecs[17] = '{1'b0, 1'b1, 8'hFF, ev_w(3'd4), ST_RDY, 8'hFF, 2'd1, 1'b0, 1'b0, 32'h11400401, 8'hE7};
    vecs[18] = '{1'b0, 1'b0, 8'h6F, ev_w(3'd6), ST_RDY, 8'hFF, 2'd3, 1'b1, 1'b1, 32'h11400401, 8'hE7};
    vecs[19] = '{1'b0, 1'b0, 8'h1D, ev_w(3'd0), ST_W2,  IMRR,  2'd0, 1'b0, 1'b0, 32'h1D000000, 8'hE7};

    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.a0 = 1'b0; bus.din = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", state, ST_IDLE);
    check("rst_init_done", init_done, 0);
    check("rst_imr", imr, IMRR);
    check("rst_icws", {icw1, icw2, icw3, icw4}, 0);
    check("rst_ocw2", ocw2, 0);
    check("rst_flags", {smm, poll_pend, rd_en, rd_sel}, 0);
    check("rst_pulses", {wr_stb, seq_err, ocw2_stb}, 0);
    repeat (SYNC + 2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_rd) bus_read(vecs[i].a0);
      else               bus_write(vecs[i].a0, vecs[i].din, vecs[i].ev);
      #1;
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_init_done", i), init_done, vecs[i].st == ST_RDY);
      check($sformatf("v%0d_imr", i), imr, vecs[i].imr);
      check($sformatf("v%0d_rd_sel", i), rd_sel, vecs[i].sel);
      check($sformatf("v%0d_smm", i), smm, vecs[i].smm);
      check($sformatf("v%0d_poll", i), poll_pend, vecs[i].poll);
      check($sformatf("v%0d_icws", i), {icw1, icw2, icw3, icw4}, vecs[i].icws);
      check($sformatf("v%0d_ocw2", i), ocw2, vecs[i].ocw2);
    end

    // a0 high selects IMR regardless of poll/read mode.
    @(negedge clk); bus.a0 = 1'b1; #1;
    check("rd_sel_a0", rd_sel, 2'b10);
    bus.a0 = 1'b0;

    // Reset while an ICW3 write strobe is still low.
    bus_write(1'b0, 8'h11, ev_w(3'd0));
    bus_write(1'b1, 8'h40, ev_w(3'd1));
    check("pre_rst_state", state, ST_W3);
    @(negedge clk);
    bus.a0 = 1'b1; bus.din = 8'h04; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    check("midrst_state", state, ST_IDLE);
    check("midrst_icw1", icw1, 0);
    bus.wr_n = 1'b1; bus.cs_n = 1'b1;
    repeat (SYNC + 6) @(negedge clk);
    check("midrst_no_commit_state", state, ST_IDLE);
    check("midrst_icw3", icw3, 0);
    bus.a0 = 1'b0;
    bus_write(1'b0, 8'h00, EV_ERR);
    check("idle_err_state", state, ST_IDLE);

    // Write released while a read is still active is rejected.
    bus_write(1'b0, 8'h12, ev_w(3'd0));
    bus_write(1'b1, 8'h20, ev_w(3'd1));
    exp_q.push_back(EV_ERR);
    @(negedge clk);
    bus.a0 = 1'b1; bus.din = 8'hFF; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    bus.wr_n = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    bus.wr_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    bus.rd_n = 1'b1; bus.cs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    bus.a0 = 1'b0;
    #1;
    check("overlap_imr", imr, IMRR);
    check("overlap_state", state, ST_RDY);

    repeat (4) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
